freelist_mw: RTL and testbench
==============================

FREELIST_MW -- requirements
Module: freelist_mw

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, giving the physical register tag width.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the entry count; DEPTH SHALL be a power of two, and DEPTH <= 2^WIDTH.
REQ-003 The block SHALL have parameter STNUM, default 0, giving the tag loaded into entry 0 at reset.
REQ-004 The block SHALL have parameter RD_PORTS, default 4, giving the allocation width.
REQ-005 The block SHALL have parameter WR_PORTS, default 4, giving the free (commit) width.
REQ-006 The block SHALL have parameter NSNAP, default 8, giving the number of branch checkpoint slots; NSNAP SHALL be a power of two. SW = log2(NSNAP). PW = log2(DEPTH)+1.
REQ-007 The block SHALL have port i_clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-008 The block SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 The block SHALL have port i_re, input, RD_PORTS bits: per-port allocate request, thermometer-coded from bit 0.
REQ-010 The block SHALL have port o_data, output, RD_PORTS*WIDTH bits: port p carries the entry at head+p.
REQ-011 The block SHALL have port o_grant, output, 1 bit: the current-cycle allocation is accepted.
REQ-012 The block SHALL have port i_we, input, WR_PORTS bits: per-port free valid, with any bit pattern legal.
REQ-013 The block SHALL have port i_wdata, input, WR_PORTS*WIDTH bits: the freed tags, one per port.
REQ-014 The block SHALL have port i_snap_en, input, 1 bit: take a checkpoint this cycle.
REQ-015 The block SHALL have port i_snap_id, input, SW bits: the checkpoint slot to write.
REQ-016 The block SHALL have port i_restore_en, input, 1 bit: roll back to a checkpoint (branch kill).
REQ-017 The block SHALL have port i_restore_id, input, SW bits: the checkpoint slot to restore from.
REQ-018 The block SHALL have port o_count, output, PW bits: the number of free entries.
REQ-019 The block SHALL have port o_err, output, 1 bit: sticky overflow/protocol error flag.

Function
REQ-020 The block SHALL store entries in a circular buffer with PW-bit head and tail pointers (MSB = wrap bit); count SHALL be defined as tail - head modulo 2^PW.
REQ-021 o_data SHALL be combinational from storage; port p SHALL read index (head+p) mod DEPTH, and ports at or beyond count SHALL carry stale data.
REQ-022 Let k = popcount(i_re). o_grant SHALL equal (k <= count) && !i_restore_en, computed combinationally.
REQ-023 When o_grant=1, head SHALL advance by k at the clock edge; when o_grant=0, head SHALL be unchanged (all-or-nothing, no partial allocation).
REQ-024 Freed tags SHALL be compacted in ascending port order and written at tail, tail+1, ..., with tail advancing by popcount(i_we).
REQ-025 Tags freed in cycle N SHALL first be allocatable in cycle N+1; there SHALL be no same-cycle bypass.
REQ-026 Simultaneous allocate and free SHALL be legal: count_next = count - k*grant + popcount(i_we).
REQ-027 If count - k*grant + popcount(i_we) > DEPTH, the block SHALL set o_err, drop the entire free, and leave tail unchanged.
REQ-028 On snapshot with i_snap_en=1 and i_restore_en=0, slot i_snap_id SHALL capture head_next, i.e. the head after this cycle's allocation.
REQ-029 On restore with i_restore_en=1, head SHALL be loaded from slot i_restore_id, allocation SHALL be suppressed, and frees that cycle SHALL still apply to tail.
REQ-030 When i_restore_en and i_snap_en are both asserted, the snapshot SHALL be ignored.
REQ-031 If a restore would make count exceed DEPTH, the block SHALL set o_err and still load head.
REQ-032 A non-thermometer i_re (a 1 above a 0) SHALL set o_err and deny the grant for that cycle.
REQ-033 Pointer arithmetic SHALL wrap modulo 2^PW; index = pointer[PW-2:0].
REQ-034 o_err SHALL clear only on reset.

Reset
REQ-035 While i_rst=1, asynchronously: entry i = STNUM+i; head=0; tail=DEPTH (wrap bit 1, index 0); all snapshot slots = 0; o_err=0.
REQ-036 Following from REQ-035, o_count=DEPTH at reset.
REQ-037 Following from REQ-035, o_data port p = STNUM+p at reset.
REQ-038 Following from REQ-035, o_grant = (k <= DEPTH).
REQ-039 Assertion of reset mid-operation SHALL discard all in-flight allocations and checkpoints.

Verification
REQ-040 Reset, then i_re=4'b1111 for 8 cycles with defaults: o_data steps 0-3, 4-7, ..., 28-31; o_count reaches 0; a 9th request gives o_grant=0 with head held.
REQ-041 With count=2, i_re=4'b0111: o_grant=0 and count stays 2; then i_re=4'b0011: grant=1 and count becomes 0.
REQ-042 With count=0, free tags 5 and 9 on ports 1 and 3 in cycle N: in cycle N+1 o_data[0]=5, o_data[1]=9 and count=2; alloc+free in the same cycle leaves count = count - k + f.
REQ-043 Snapshot slot 3 with i_re=4'b0011 at head=4 (slot captures 6); allocate 8 more; restore slot 3: head=6 and count rises by 8; a simultaneous free of 1 tag gives count +9.
REQ-044 With count=DEPTH, free 1 tag: o_err=1 and tail/count unchanged; i_re=4'b0101 sets o_err; only i_rst clears o_err.
REQ-045 Assert i_rst asynchronously between clock edges mid-stream: outputs immediately return to their reset values (o_count=32, o_data={3,2,1,0}).

Source files
------------

// File: rtl/freelist_mw.sv
// rtl/freelist_mw.sv - multi-port physical register free list with branch checkpoints
// Allocation pops from head, commits push compacted tags at tail, checkpoints save head.
module freelist_mw #(
  parameter int WIDTH    = 7,
  parameter int DEPTH    = 32,
  parameter int STNUM    = 0,
  parameter int RD_PORTS = 4,
  parameter int WR_PORTS = 4,
  parameter int NSNAP    = 8,
  localparam int SW      = $clog2(NSNAP),
  localparam int PW      = $clog2(DEPTH) + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [RD_PORTS-1:0]          i_re,
  output logic [RD_PORTS*WIDTH-1:0]    o_data,
  output logic                         o_grant,
  input  logic [WR_PORTS-1:0]          i_we,
  input  logic [WR_PORTS*WIDTH-1:0]    i_wdata,
  input  logic                         i_snap_en,
  input  logic [SW-1:0]                i_snap_id,
  input  logic                         i_restore_en,
  input  logic [SW-1:0]                i_restore_id,
  output logic [PW-1:0]                o_count,
  output logic                         o_err
);

  logic [WIDTH-1:0]    mem_q  [DEPTH];
  logic [WIDTH-1:0]    mem_d  [DEPTH];
  logic [PW-1:0]       snap_q [NSNAP];
  logic [PW-1:0]       snap_d [NSNAP];
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic                err_q, err_d;

  logic [PW-1:0]       count;
  logic [31:0]         k, f, base;
  logic [RD_PORTS-1:0] re_inc;
  logic                thermo_ok, grant, drop;
  logic [PW-2:0]       widx, off, ridx;

  always_comb begin
    count = tail_q - head_q;
    k = '0;
    for (int p = 0; p < RD_PORTS; p++) k = k + 32'(i_re[p]);
    f = '0;
    for (int w = 0; w < WR_PORTS; w++) f = f + 32'(i_we[w]);

    // A thermometer code plus one has no bits in common with itself.
    re_inc    = i_re + RD_PORTS'(1);
    thermo_ok = ((i_re & re_inc) == '0);
    grant     = thermo_ok && !i_restore_en && (k <= 32'(count));

    head_d = i_restore_en ? snap_q[i_restore_id]
                          : head_q + (grant ? k[PW-1:0] : '0);

    // Occupancy after this cycle's head move; a free that would overfill is dropped whole.
    base   = 32'(PW'(tail_q - head_d));
    drop   = (base + f) > 32'(DEPTH);
    err_d  = err_q || !thermo_ok || drop;
    tail_d = drop ? tail_q : tail_q + f[PW-1:0];

    mem_d = mem_q;
    off   = '0;
    widx  = '0;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (i_we[w]) begin
        widx = tail_q[PW-2:0] + off;
        if (!drop) mem_d[widx] = i_wdata[w*WIDTH +: WIDTH];
        off = off + (PW-1)'(1);
      end
    end

    snap_d = snap_q;
    if (i_snap_en && !i_restore_en) snap_d[i_snap_id] = head_d;
  end

  always_comb begin
    o_data = '0;
    ridx   = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      ridx = head_q[PW-2:0] + (PW-1)'(p);
      o_data[p*WIDTH +: WIDTH] = mem_q[ridx];
    end
  end

  assign o_count = count;
  assign o_grant = grant;
  assign o_err   = err_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_q <= '0;
      tail_q <= PW'(DEPTH);
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(STNUM + i);
      for (int i = 0; i < NSNAP; i++) snap_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
      mem_q  <= mem_d;
      snap_q <= snap_d;
    end
  end

endmodule

// File: tb/tb_freelist_mw.sv
// tb/tb_freelist_mw.sv - directed and random checks of freelist_mw against a ring model
module tb_freelist_mw;
  localparam int WIDTH = 7;
  localparam int DEPTH = 32;
  localparam int RP    = 4;
  localparam int WP    = 4;
  localparam int NS    = 8;
  localparam int SW    = 3;
  localparam int PW    = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [RP-1:0]     i_re;
  logic [RP*WIDTH-1:0] o_data;
  logic              o_grant;
  logic [WP-1:0]     i_we;
  logic [WP*WIDTH-1:0] i_wdata;
  logic              i_snap_en;
  logic [SW-1:0]     i_snap_id;
  logic              i_restore_en;
  logic [SW-1:0]     i_restore_id;
  logic [PW-1:0]     o_count;
  logic              o_err;

  freelist_mw dut (
    .i_clk(clk), .i_rst(rst), .i_re(i_re), .o_data(o_data), .o_grant(o_grant),
    .i_we(i_we), .i_wdata(i_wdata), .i_snap_en(i_snap_en), .i_snap_id(i_snap_id),
    .i_restore_en(i_restore_en), .i_restore_id(i_restore_id),
    .o_count(o_count), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: tags live at absolute positions mod DEPTH; positions counted mod 2*DEPTH.
  int ring [DEPTH];
  int m_head, m_tail;
  int m_snap [NS];
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ring[i] = i;
    for (int i = 0; i < NS; i++) m_snap[i] = 0;
    m_head = 0;
    m_tail = DEPTH;
    m_err  = 1'b0;
  endtask

  function automatic int m_count();
    return (m_tail - m_head) & (2*DEPTH - 1);
  endfunction

  function automatic logic [WP*WIDTH-1:0] pack(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  // Called at posedge+1; checks combinational outputs, then advances one clock.
  task automatic step(input logic [RP-1:0] re, input logic [WP-1:0] we,
                      input logic [WP*WIDTH-1:0] wd, input logic se, input logic [SW-1:0] sid,
                      input logic ren, input logic [SW-1:0] rid);
    int cnt, k, f, nh, base, off;
    bit thermo, grant, drop;
    i_re = re; i_we = we; i_wdata = wd;
    i_snap_en = se; i_snap_id = sid; i_restore_en = ren; i_restore_id = rid;
    #3;
    cnt    = m_count();
    k      = $countones(re);
    thermo = (re == 4'b0000) || (re == 4'b0001) || (re == 4'b0011) ||
             (re == 4'b0111) || (re == 4'b1111);
    grant  = thermo && !ren && (k <= cnt);
    chk("grant", 32'(o_grant), 32'(grant));
    chk("count", 32'(o_count), cnt);
    chk("err", 32'(o_err), 32'(m_err));
    for (int p = 0; p < RP; p++)
      if (p < cnt) chk($sformatf("data%0d", p), 32'(o_data[p*WIDTH +: WIDTH]), ring[(m_head + p) % DEPTH]);
    nh   = ren ? m_snap[rid] : (m_head + (grant ? k : 0)) % (2*DEPTH);
    base = (m_tail - nh) & (2*DEPTH - 1);
    f    = $countones(we);
    drop = (base + f) > DEPTH;
    @(posedge clk);
    if (!thermo || drop) m_err = 1'b1;
    if (!drop) begin
      off = 0;
      for (int w = 0; w < WP; w++)
        if (we[w]) begin
          ring[(m_tail + off) % DEPTH] = int'(wd[w*WIDTH +: WIDTH]);
          off++;
        end
      m_tail = (m_tail + f) % (2*DEPTH);
    end
    if (se && !ren) m_snap[sid] = nh;
    m_head = nh;
    #1;
  endtask

  task automatic idle_inputs();
    i_re = '0; i_we = '0; i_wdata = '0;
    i_snap_en = 1'b0; i_snap_id = '0; i_restore_en = 1'b0; i_restore_id = '0;
  endtask

  // Reset asserted between edges; outputs must return to reset values at once.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_count"}, 32'(o_count), DEPTH);
    chk({tag, "_err"}, 32'(o_err), 0);
    for (int p = 0; p < RP; p++)
      chk($sformatf("%s_data%0d", tag, p), 32'(o_data[p*WIDTH +: WIDTH]), p);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  initial begin
    logic [RP-1:0] re;
    logic [WP-1:0] we;
    int n;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_count", 32'(o_count), DEPTH);
    chk("rst_grant", 32'(o_grant), 1);
    chk("rst_err", 32'(o_err), 0);
    for (int p = 0; p < RP; p++) chk($sformatf("rst_data%0d", p), 32'(o_data[p*WIDTH +: WIDTH]), p);
    @(posedge clk); #1;
    rst = 1'b0;

    // Drain the whole list four at a time.
    for (int i = 0; i < 8; i++) begin
      chk("drain_data0", 32'(o_data[6:0]), 4*i);
      step(4'b1111, 4'b0000, '0, 0, 0, 0, 0);
    end
    chk("drain_empty", 32'(o_count), 0);
    step(4'b1111, 4'b0000, '0, 0, 0, 0, 0);
    chk("drain_held", 32'(o_count), 0);

    // Sparse free, then all-or-nothing grant at count 2.
    step(4'b0000, 4'b1010, pack(0, 5, 0, 9), 0, 0, 0, 0);
    chk("free_d0", 32'(o_data[6:0]), 5);
    chk("free_d1", 32'(o_data[13:7]), 9);
    chk("free_cnt", 32'(o_count), 2);
    step(4'b0111, 4'b0000, '0, 0, 0, 0, 0);
    chk("deny_cnt", 32'(o_count), 2);
    step(4'b0011, 4'b0000, '0, 0, 0, 0, 0);
    chk("grant_cnt", 32'(o_count), 0);
    step(4'b0000, 4'b1111, pack(10, 11, 12, 13), 0, 0, 0, 0);
    step(4'b0011, 4'b0110, pack(0, 20, 21, 0), 0, 0, 0, 0);
    chk("allocfree_cnt", 32'(o_count), 4);

    // Checkpoint and restore.
    do_reset("rst1");
    step(4'b1111, 4'b0000, '0, 0, 0, 0, 0);
    step(4'b0011, 4'b0000, '0, 1, 3, 0, 0);
    step(4'b1111, 4'b0000, '0, 0, 0, 0, 0);
    step(4'b1111, 4'b0000, '0, 0, 0, 0, 0);
    chk("pre_restore_cnt", 32'(o_count), 18);
    step(4'b0000, 4'b0001, pack(40, 0, 0, 0), 0, 0, 1, 3);
    chk("restore_cnt", 32'(o_count), 27);
    chk("restore_d0", 32'(o_data[6:0]), 6);

    // Overflow and protocol errors are sticky until reset.
    do_reset("rst2");
    step(4'b0000, 4'b0001, pack(50, 0, 0, 0), 0, 0, 0, 0);
    chk("ovf_err", 32'(o_err), 1);
    chk("ovf_cnt", 32'(o_count), DEPTH);
    do_reset("rst3");
    step(4'b0101, 4'b0000, '0, 0, 0, 0, 0);
    chk("nonthermo_err", 32'(o_err), 1);
    chk("nonthermo_cnt", 32'(o_count), DEPTH);
    step(4'b0000, 4'b0000, '0, 0, 0, 0, 0);
    chk("err_sticky", 32'(o_err), 1);
    do_reset("rst4");

    // Random traffic, with an asynchronous reset midway.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rst_mid");
      if ($urandom_range(0, 19) < 18) begin
        n  = $urandom_range(0, RP);
        re = RP'((1 << n) - 1);
      end else begin
        re = RP'($urandom_range(0, 15));
      end
      we = (m_count() > DEPTH - 6) ? 4'b0000 : WP'($urandom_range(0, 15));
      step(re, we, (WP*WIDTH)'({$urandom, $urandom}),
           ($urandom_range(0, 3) == 0), SW'($urandom_range(0, NS-1)),
           ($urandom_range(0, 15) == 0), SW'($urandom_range(0, NS-1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
